// File: rtl/hex_rate_counter.sv
// hex_rate_counter: rate-divided 4-bit up/down counter that feeds a hex-to-7-segment decoder.
// Ports:
//   CLOCK_50   - system clock; all logic runs on the rising edge
//   resetn     - synchronous active-low reset
//   speed      - rate select: 00 every cycle, 01 CLK_FREQ, 10 2*CLK_FREQ, 11 4*CLK_FREQ cycles
//   enable     - 1 lets the divider run and the counter step; 0 holds both
//   up         - step direction, 1 = increment, 0 = decrement
//   load       - synchronous parallel load strobe
//   load_value - value captured on load
//   hex_value  - current count, bit 3 MSB
//   tick       - one-cycle pulse in the cycle hex_value shows a newly stepped value
//   wrap       - pulse coincident with tick when the step crossed F->0 or 0->F
module hex_rate_counter #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned DIV_WIDTH = 28
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [1:0] speed,
  input  logic       enable,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic [3:0] hex_value,
  output logic       tick,
  output logic       wrap
);

  localparam logic [DIV_WIDTH-1:0] RELOAD_1X = DIV_WIDTH'(CLK_FREQ - 1);
  localparam logic [DIV_WIDTH-1:0] RELOAD_2X = DIV_WIDTH'(2 * CLK_FREQ - 1);
  localparam logic [DIV_WIDTH-1:0] RELOAD_4X = DIV_WIDTH'(4 * CLK_FREQ - 1);

  logic [DIV_WIDTH-1:0] div;
  logic [1:0]           spd_q;

  logic [DIV_WIDTH-1:0] reload_c;
  logic [DIV_WIDTH-1:0] div_nxt;
  logic [1:0]           spd_nxt;
  logic [3:0]           hex_nxt;
  logic                 tick_nxt;
  logic                 wrap_nxt;

  // Divider reload value (period minus one) for the currently selected speed
  always_comb begin
    reload_c = '0;
    case (speed)
      2'b00:   reload_c = '0;
      2'b01:   reload_c = RELOAD_1X;
      2'b10:   reload_c = RELOAD_2X;
      default: reload_c = RELOAD_4X;
    endcase
  end

  // Next-state selection; load outranks speed change, which outranks enable
  always_comb begin
    div_nxt  = div;
    spd_nxt  = spd_q;
    hex_nxt  = hex_value;
    tick_nxt = 1'b0;
    wrap_nxt = 1'b0;
    if (load) begin
      hex_nxt = load_value;
      div_nxt = reload_c;
      spd_nxt = speed;
    end else if (speed != spd_q) begin
      // A speed change restarts the period and never steps, even if div is 0
      div_nxt = reload_c;
      spd_nxt = speed;
    end else if (enable) begin
      if (div != '0) begin
        div_nxt = div - DIV_WIDTH'(1);
      end else begin
        div_nxt  = reload_c;
        tick_nxt = 1'b1;
        if (up) begin
          hex_nxt  = hex_value + 4'd1;
          wrap_nxt = (hex_value == 4'hF);
        end else begin
          hex_nxt  = hex_value - 4'd1;
          wrap_nxt = (hex_value == 4'h0);
        end
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      hex_value <= 4'h0;
      div       <= reload_c;
      spd_q     <= speed;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      hex_value <= hex_nxt;
      div       <= div_nxt;
      spd_q     <= spd_nxt;
      tick      <= tick_nxt;
      wrap      <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_hex_rate_counter.sv
// Directed testbench for hex_rate_counter with a small CLK_FREQ.
module tb_hex_rate_counter;

  localparam int unsigned CLK_FREQ  = 8;
  localparam int unsigned DIV_WIDTH = 6;

  logic       clk;
  logic       resetn;
  logic [1:0] speed;
  logic       enable;
  logic       up;
  logic       load;
  logic [3:0] load_value;
  logic [3:0] hex_value;
  logic       tick;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  hex_rate_counter #(
    .CLK_FREQ  (CLK_FREQ),
    .DIV_WIDTH (DIV_WIDTH)
  ) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .speed      (speed),
    .enable     (enable),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .hex_value  (hex_value),
    .tick       (tick),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it
  task automatic edge_once();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; speed = 2'b01; enable = 1'b1; up = 1'b1; load = 1'b0; load_value = 4'h0;
    edge_once();
    checks++;
    if ({hex_value, tick, wrap} !== {4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got hex=%h tick=%b wrap=%b, want hex=0 tick=0 wrap=0", hex_value, tick, wrap);
    end
    resetn = 1'b1;
  endtask

  // speed=01 from reset: steps on edges 8 and 16
  task automatic test_rate_1x();
    logic [3:0] exp_hex;
    logic       exp_tick;
    for (int e = 1; e <= 16; e++) begin
      edge_once();
      exp_hex  = (e >= 16) ? 4'h2 : (e >= 8) ? 4'h1 : 4'h0;
      exp_tick = (e == 8) || (e == 16);
      checks++;
      if ({hex_value, tick, wrap} !== {exp_hex, exp_tick, 1'b0}) begin
        errors++;
        $display("FAIL rate_1x edge %0d: got hex=%h tick=%b wrap=%b, want hex=%h tick=%b wrap=0",
                 e, hex_value, tick, wrap, exp_hex, exp_tick);
      end
    end
  endtask

  // speed=00: load E, then one step per enabled cycle across the F->0 wrap
  task automatic test_full_rate_wrap();
    logic [3:0] exp_hex [4] = '{4'hE, 4'hF, 4'h0, 4'h1};
    logic       exp_tick[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic       exp_wrap[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    speed = 2'b00; up = 1'b1; enable = 1'b0; load = 1'b1; load_value = 4'hE;
    edge_once();
    load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) edge_once();
      checks++;
      if ({hex_value, tick, wrap} !== {exp_hex[i], exp_tick[i], exp_wrap[i]}) begin
        errors++;
        $display("FAIL full_rate step %0d: got hex=%h tick=%b wrap=%b, want hex=%h tick=%b wrap=%b",
                 i, hex_value, tick, wrap, exp_hex[i], exp_tick[i], exp_wrap[i]);
      end
    end
  endtask

  // speed=10 down from 0: first step after 16 enabled cycles gives F with wrap
  task automatic test_down_wrap();
    speed = 2'b10; up = 1'b0; enable = 1'b1; load = 1'b1; load_value = 4'h0;
    edge_once();
    load = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      edge_once();
      checks++;
      if (e < 16 && {hex_value, tick, wrap} !== {4'h0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL down_wait edge %0d: got hex=%h tick=%b wrap=%b, want 0/0/0", e, hex_value, tick, wrap);
      end else if (e == 16 && {hex_value, tick, wrap} !== {4'hF, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL down_step: got hex=%h tick=%b wrap=%b, want hex=F tick=1 wrap=1", hex_value, tick, wrap);
      end
    end
  endtask

  // enable low for edges 3..7 stretches the first period to edge 13
  task automatic test_enable_gap();
    speed = 2'b01; up = 1'b1; enable = 1'b1; load = 1'b1; load_value = 4'h0;
    edge_once();
    load = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      enable = !(e >= 3 && e <= 7);
      edge_once();
      checks++;
      if (e < 13 && {hex_value, tick} !== {4'h0, 1'b0}) begin
        errors++;
        $display("FAIL gap_hold edge %0d: got hex=%h tick=%b, want hex=0 tick=0", e, hex_value, tick);
      end else if (e == 13 && {hex_value, tick, wrap} !== {4'h1, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL gap_step: got hex=%h tick=%b wrap=%b, want hex=1 tick=1 wrap=0", hex_value, tick, wrap);
      end
    end
    enable = 1'b1;
  endtask

  // load on a would-step edge, then speed change on a would-step edge
  task automatic test_load_and_speed_change();
    speed = 2'b01; up = 1'b1; enable = 1'b1; load = 1'b1; load_value = 4'h3;
    edge_once();
    load = 1'b0;
    for (int e = 1; e <= 7; e++) edge_once();
    load = 1'b1; load_value = 4'h7;
    edge_once();
    load = 1'b0;
    checks++;
    if ({hex_value, tick, wrap} !== {4'h7, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL load_collision: got hex=%h tick=%b wrap=%b, want hex=7 tick=0 wrap=0", hex_value, tick, wrap);
    end
    for (int e = 1; e <= 7; e++) edge_once();
    speed = 2'b11;
    edge_once();
    checks++;
    if ({hex_value, tick, wrap} !== {4'h7, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL speed_change: got hex=%h tick=%b wrap=%b, want hex=7 tick=0 wrap=0", hex_value, tick, wrap);
    end
    for (int e = 1; e <= 32; e++) begin
      edge_once();
      checks++;
      if (e < 32 && {hex_value, tick} !== {4'h7, 1'b0}) begin
        errors++;
        $display("FAIL slow_hold edge %0d: got hex=%h tick=%b, want hex=7 tick=0", e, hex_value, tick);
      end else if (e == 32 && {hex_value, tick, wrap} !== {4'h8, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL slow_step: got hex=%h tick=%b wrap=%b, want hex=8 tick=1 wrap=0", hex_value, tick, wrap);
      end
    end
  endtask

  // reset mid-period at 9 clears the count and restarts a full period
  task automatic test_reset_mid_count();
    speed = 2'b01; up = 1'b1; enable = 1'b1; load = 1'b1; load_value = 4'h9;
    edge_once();
    load = 1'b0;
    for (int e = 1; e <= 3; e++) edge_once();
    checks++;
    if (hex_value !== 4'h9) begin
      errors++;
      $display("FAIL pre_reset: got hex=%h, want hex=9", hex_value);
    end
    resetn = 1'b0;
    edge_once();
    resetn = 1'b1;
    checks++;
    if ({hex_value, tick, wrap} !== {4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got hex=%h tick=%b wrap=%b, want 0/0/0", hex_value, tick, wrap);
    end
    for (int e = 1; e <= 8; e++) begin
      edge_once();
      checks++;
      if (e < 8 && {hex_value, tick} !== {4'h0, 1'b0}) begin
        errors++;
        $display("FAIL post_reset_hold edge %0d: got hex=%h tick=%b, want hex=0 tick=0", e, hex_value, tick);
      end else if (e == 8 && {hex_value, tick, wrap} !== {4'h1, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL post_reset_step: got hex=%h tick=%b wrap=%b, want hex=1 tick=1 wrap=0", hex_value, tick, wrap);
      end
    end
  endtask

  initial begin
    resetn = 1'b0; speed = 2'b01; enable = 1'b0; up = 1'b1; load = 1'b0; load_value = 4'h0;
    test_reset();
    test_rate_1x();
    test_full_rate_wrap();
    test_down_wrap();
    test_enable_gap();
    test_load_and_speed_change();
    test_reset_mid_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
